// File: rtl/eq_coeff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eq_coeff_pkg
// Description : Shared definitions for the equalizer coefficient loader:
//               eq_coeff register field positions, loader state encoding
//               and the optional status word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package eq_coeff_pkg;

    // eq_coeff software register word layout
    localparam int c_cfg_wr_tog_bit     = 31;
    localparam int c_cfg_commit_tog_bit = 30;
    localparam int c_cfg_addr_lsb       = 16;
    localparam int c_cfg_addr_max_w     = 14;
    localparam int c_cfg_coeff_lsb      = 0;
    localparam int c_cfg_coeff_max_w    = 16;

    // Bank-swap sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        SWAP      = 2'd2
    } loader_state_t;

    // Status word layout (only used when EQ_COEFF_STATUS_EN is defined)
    localparam int c_stat_swap_cnt_lsb = 16;
    localparam int c_stat_swap_cnt_w   = 16;
    localparam int c_stat_pending_bit  = 15;
    localparam int c_stat_busy_bit     = 14;
    localparam int c_stat_bank_bit     = 13;

    function automatic logic [31:0] pack_status(
        input logic [c_stat_swap_cnt_w-1:0] swap_count,
        input logic                         pending,
        input logic                         busy,
        input logic                         bank
    );
        logic [31:0] w;
        w                                        = '0;
        w[c_stat_swap_cnt_lsb +: c_stat_swap_cnt_w] = swap_count;
        w[c_stat_pending_bit]                    = pending;
        w[c_stat_busy_bit]                       = busy;
        w[c_stat_bank_bit]                       = bank;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eq_coeff_loader_toggle_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : toggle_edge_det
// Description : Detects a change of a software toggle bit. The first cycle
//               after reset only captures the current level (priming), so a
//               toggle already sitting at 1 never produces an event.
// Ports       : clk   - clock
//               rst   - synchronous active-high reset
//               i_tog - registered toggle level
//               o_evt - high for one cycle when i_tog differs from last cycle
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_tog,
    output logic o_evt
);

    logic r_primed;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_primed <= 1'b0;
            r_prev   <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            r_prev   <= i_tog;
        end
    end

    assign o_evt = r_primed & (i_tog ^ r_prev);

endmodule
`default_nettype wire

// File: rtl/eq_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : eq_coeff_loader
// Description : Double-buffered equalizer coefficient loader. Software writes
//               coefficients into the shadow bank via a write toggle and
//               requests a bank swap via a commit toggle; the swap happens on
//               the next datapath frame sync. Writes arriving while a swap is
//               pending are held (last one wins) and issued right after the
//               swap into the new shadow bank.
// Ports       : user_clk    - clock (rising edge)
//               user_rst    - synchronous active-high reset
//               cfg_word    - eq_coeff register word {wr_tog, commit_tog,
//                             addr[29:16], coeff[15:0]}
//               sync_in     - datapath frame sync pulse
//               ram_we      - one-cycle coefficient RAM write strobe
//               ram_waddr   - {shadow bank, address}
//               ram_wdata   - coefficient value
//               active_bank - bank read by the equalizer datapath
//               commit_done - one-cycle pulse on each bank swap
//               busy        - commit pending
//               status_word - {swap_count, pending, busy, bank, 13'b0};
//                             present only with EQ_COEFF_STATUS_EN defined
// Revision    : 1.0 - initial release
// ============================================================================
module eq_coeff_loader
    import eq_coeff_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int COEFF_W = 16
) (
    input  logic               user_clk,
    input  logic               user_rst,
    input  logic [31:0]        cfg_word,
    input  logic               sync_in,
    output logic               ram_we,
    output logic [ADDR_W:0]    ram_waddr,
    output logic [COEFF_W-1:0] ram_wdata,
    output logic               active_bank,
    output logic               commit_done,
    output logic               busy
`ifdef EQ_COEFF_STATUS_EN
    ,
    output logic [31:0]        status_word
`endif
);

    logic [31:0]        r_cfg_q;
    logic               w_unused_cfg;
    logic [ADDR_W-1:0]  w_cfg_addr;
    logic [COEFF_W-1:0] w_cfg_coeff;
    logic               w_wr_ev;
    logic               w_cm_ev;

    loader_state_t      r_state;
    loader_state_t      w_state_next;

    logic               r_active_bank;
    logic               r_ram_we;
    logic [ADDR_W:0]    r_ram_waddr;
    logic [COEFF_W-1:0] r_ram_wdata;
    logic               r_pend_valid;
    logic [ADDR_W-1:0]  r_pend_addr;
    logic [COEFF_W-1:0] r_pend_coeff;

    logic               w_swap_start;
    logic               w_direct_wr;

    // Deliberately not reset: it keeps tracking cfg_word during reset so the
    // edge detectors prime on the live register value.
    always_ff @(posedge user_clk) begin
        r_cfg_q <= cfg_word;
    end

    assign w_cfg_addr   = r_cfg_q[c_cfg_addr_lsb +: ADDR_W];
    assign w_cfg_coeff  = r_cfg_q[c_cfg_coeff_lsb +: COEFF_W];
    assign w_unused_cfg = ^r_cfg_q;

    toggle_edge_det u_wr_tog (
        .clk   (user_clk),
        .rst   (user_rst),
        .i_tog (r_cfg_q[c_cfg_wr_tog_bit]),
        .o_evt (w_wr_ev)
    );

    toggle_edge_det u_commit_tog (
        .clk   (user_clk),
        .rst   (user_rst),
        .i_tog (r_cfg_q[c_cfg_commit_tog_bit]),
        .o_evt (w_cm_ev)
    );

    // ---------------- bank-swap sequencer ----------------
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sync is only looked at in WAIT_SYNC, so a sync coinciding with the
    // commit event can never trigger the swap.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        commit_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cm_ev) begin
                    w_state_next = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                busy = 1'b1;
                if (sync_in) begin
                    w_state_next = SWAP;
                end
            end
            SWAP: begin
                busy         = 1'b1;
                commit_done  = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- write path and bank register ----------------
    // The bank flips on entry to SWAP, so any write leaving SWAP targets
    // ~active_bank = the new shadow bank. In IDLE the same expression gives
    // the pre-swap shadow bank, which covers coincident write+commit.
    assign w_swap_start = (r_state == WAIT_SYNC) && sync_in;
    assign w_direct_wr  = w_wr_ev && (r_state != WAIT_SYNC);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_active_bank <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_waddr   <= '0;
            r_ram_wdata   <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_addr   <= '0;
            r_pend_coeff  <= '0;
        end else begin
            r_ram_we <= 1'b0;

            if (w_swap_start) begin
                r_active_bank <= ~r_active_bank;
            end

            // A fresh write during SWAP supersedes the held one.
            if (w_direct_wr) begin
                r_ram_we    <= 1'b1;
                r_ram_waddr <= {~r_active_bank, w_cfg_addr};
                r_ram_wdata <= w_cfg_coeff;
            end else if ((r_state == SWAP) && r_pend_valid) begin
                r_ram_we    <= 1'b1;
                r_ram_waddr <= {~r_active_bank, r_pend_addr};
                r_ram_wdata <= r_pend_coeff;
            end

            if (r_state == SWAP) begin
                r_pend_valid <= 1'b0;
            end else if (w_wr_ev && (r_state == WAIT_SYNC)) begin
                r_pend_valid <= 1'b1;
                r_pend_addr  <= w_cfg_addr;
                r_pend_coeff <= w_cfg_coeff;
            end
        end
    end

    assign ram_we      = r_ram_we;
    assign ram_waddr   = r_ram_waddr;
    assign ram_wdata   = r_ram_wdata;
    assign active_bank = r_active_bank;

`ifdef EQ_COEFF_STATUS_EN
    logic [c_stat_swap_cnt_w-1:0] r_swap_count;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_swap_count <= '0;
        end else if (w_swap_start) begin
            r_swap_count <= r_swap_count + 1'b1;
        end
    end

    assign status_word = pack_status(r_swap_count, r_pend_valid, busy, r_active_bank);
`endif

endmodule
`default_nettype wire

// File: tb/tb_eq_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_eq_coeff_loader
// Description : Self-checking bench for eq_coeff_loader: directed scenarios
//               followed by randomized register/sync/reset traffic, all
//               compared each cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_coeff_loader;

    localparam int ADDR_W  = 11;
    localparam int COEFF_W = 16;

    logic               user_clk;
    logic               user_rst;
    logic [31:0]        cfg_word;
    logic               sync_in;
    logic               ram_we;
    logic [ADDR_W:0]    ram_waddr;
    logic [COEFF_W-1:0] ram_wdata;
    logic               active_bank;
    logic               commit_done;
    logic               busy;

    int n_checks = 0;
    int n_bad    = 0;

    eq_coeff_loader #(
        .ADDR_W  (ADDR_W),
        .COEFF_W (COEFF_W)
    ) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .cfg_word    (cfg_word),
        .sync_in     (sync_in),
        .ram_we      (ram_we),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .active_bank (active_bank),
        .commit_done (commit_done),
        .busy        (busy)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // ---------------- behavioural reference ----------------
    // Events come straight from the cfg_word history: a toggle change
    // between the two previous samples, with reset absent on both of the
    // last two edges.
    logic [31:0]        h_word1 = '0;
    logic [31:0]        h_word2 = '0;
    logic               h_rst1  = 1'b1;

    logic               m_waiting  = 1'b0;
    logic               m_swapping = 1'b0;
    logic               m_bank     = 1'b0;
    logic               m_pend     = 1'b0;
    logic [ADDR_W-1:0]  m_pend_addr  = '0;
    logic [COEFF_W-1:0] m_pend_coeff = '0;
    logic               m_we    = 1'b0;
    logic [ADDR_W:0]    m_waddr = '0;
    logic [COEFF_W-1:0] m_wdata = '0;

    always @(posedge user_clk) begin : model
        logic               wr;
        logic               cm;
        logic [ADDR_W-1:0]  a;
        logic [COEFF_W-1:0] c;
        wr = !user_rst && !h_rst1 && (h_word1[31] != h_word2[31]);
        cm = !user_rst && !h_rst1 && (h_word1[30] != h_word2[30]);
        a  = h_word1[16 +: ADDR_W];
        c  = h_word1[0 +: COEFF_W];
        if (user_rst) begin
            m_waiting  = 1'b0;
            m_swapping = 1'b0;
            m_bank     = 1'b0;
            m_pend     = 1'b0;
            m_we       = 1'b0;
            m_waddr    = '0;
            m_wdata    = '0;
        end else begin
            m_we = 1'b0;
            if (m_swapping) begin
                m_swapping = 1'b0;
                if (wr) begin
                    m_we = 1'b1; m_waddr = {~m_bank, a}; m_wdata = c;
                end else if (m_pend) begin
                    m_we = 1'b1; m_waddr = {~m_bank, m_pend_addr}; m_wdata = m_pend_coeff;
                end
                m_pend = 1'b0;
            end else if (m_waiting) begin
                if (wr) begin
                    m_pend = 1'b1; m_pend_addr = a; m_pend_coeff = c;
                end
                if (sync_in) begin
                    m_waiting  = 1'b0;
                    m_swapping = 1'b1;
                    m_bank     = ~m_bank;
                end
            end else begin
                if (wr) begin
                    m_we = 1'b1; m_waddr = {~m_bank, a}; m_wdata = c;
                end
                if (cm) m_waiting = 1'b1;
            end
        end
        h_word2 = h_word1;
        h_word1 = cfg_word;
        h_rst1  = user_rst;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        @(negedge user_clk);
        check("m_ram_we",      32'(ram_we),      32'(m_we));
        check("m_ram_waddr",   32'(ram_waddr),   32'(m_waddr));
        check("m_ram_wdata",   32'(ram_wdata),   32'(m_wdata));
        check("m_active_bank", 32'(active_bank), 32'(m_bank));
        check("m_commit_done", 32'(commit_done), 32'(m_swapping));
        check("m_busy",        32'(busy),        32'(m_waiting | m_swapping));
    endtask

    task automatic do_reset(input logic [31:0] word);
        user_rst = 1'b1;
        cfg_word = word;
        sync_in  = 1'b0;
        repeat (3) step();
        check("rst_we",    32'(ram_we),      32'h0);
        check("rst_waddr", 32'(ram_waddr),   32'h0);
        check("rst_wdata", 32'(ram_wdata),   32'h0);
        check("rst_bank",  32'(active_bank), 32'h0);
        check("rst_done",  32'(commit_done), 32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        user_rst = 1'b0;
        repeat (2) step();
    endtask

    logic [31:0] cur;

    initial begin
        user_rst = 1'b1;
        cfg_word = '0;
        sync_in  = 1'b0;

        // Single write lands in the shadow bank two cycles later, once
        do_reset(32'h0);
        cfg_word = 32'h8123_ABCD;
        step();
        check("w1_early_we", 32'(ram_we), 32'h0);
        step();
        check("w1_we",    32'(ram_we),    32'h1);
        check("w1_waddr", 32'(ram_waddr), 32'h923);
        check("w1_wdata", 32'(ram_wdata), 32'hABCD);
        step();
        check("w1_once", 32'(ram_we), 32'h0);

        // Commit, sync ten cycles later
        do_reset(32'h0);
        cfg_word = 32'h4000_0000;
        step();
        check("c1_busy_pre", 32'(busy), 32'h0);
        step();
        check("c1_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("c1_wait_busy", 32'(busy),        32'h1);
            check("c1_wait_done", 32'(commit_done), 32'h0);
        end
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("c1_done", 32'(commit_done), 32'h1);
        check("c1_bank", 32'(active_bank), 32'h1);
        step();
        check("c1_done_end", 32'(commit_done), 32'h0);
        check("c1_busy_end", 32'(busy),        32'h0);
        check("c1_bank_end", 32'(active_bank), 32'h1);

        // Write + commit + sync all together: write to bank 1, swap later
        do_reset(32'h0);
        cfg_word = 32'hC055_1234;
        sync_in  = 1'b1;
        step();
        sync_in = 1'b0;
        check("wc_we_pre", 32'(ram_we), 32'h0);
        step();
        check("wc_we",    32'(ram_we),    32'h1);
        check("wc_waddr", 32'(ram_waddr), 32'h855);
        check("wc_wdata", 32'(ram_wdata), 32'h1234);
        check("wc_busy",  32'(busy),      32'h1);
        repeat (3) step();
        check("wc_noswap_done", 32'(commit_done), 32'h0);
        check("wc_noswap_bank", 32'(active_bank), 32'h0);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("wc_swap_done", 32'(commit_done), 32'h1);
        check("wc_swap_bank", 32'(active_bank), 32'h1);
        step();

        // Two writes while waiting: only the last, after the swap
        do_reset(32'h0);
        cfg_word = 32'h4000_0000;
        repeat (2) step();
        cfg_word = 32'hC0AA_0001;
        step();
        cfg_word = 32'h40AA_0002;
        for (int i = 0; i < 4; i++) begin
            step();
            check("pw_held_we", 32'(ram_we), 32'h0);
        end
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("pw_swap_done", 32'(commit_done), 32'h1);
        check("pw_swap_we",   32'(ram_we),      32'h0);
        step();
        check("pw_we",    32'(ram_we),    32'h1);
        check("pw_waddr", 32'(ram_waddr), 32'h0AA);
        check("pw_wdata", 32'(ram_wdata), 32'h0002);
        step();
        check("pw_once", 32'(ram_we), 32'h0);

        // Toggles high across reset release; reset abandons a pending commit
        do_reset(32'hC000_0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("pr_we",   32'(ram_we), 32'h0);
            check("pr_busy", 32'(busy),   32'h0);
        end
        cfg_word = 32'h8000_0000;
        repeat (2) step();
        check("ra_busy", 32'(busy), 32'h1);
        user_rst = 1'b1;
        step();
        check("ra_rst_busy", 32'(busy),        32'h0);
        check("ra_rst_bank", 32'(active_bank), 32'h0);
        user_rst = 1'b0;
        step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("ra_done", 32'(commit_done), 32'h0);
        check("ra_bank", 32'(active_bank), 32'h0);
        step();
        check("ra_we",    32'(ram_we),      32'h0);
        check("ra_bank2", 32'(active_bank), 32'h0);

        // Randomized traffic against the model
        cur = cfg_word;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 15) begin
                cur[31]    = ~cur[31];
                cur[29:16] = 14'($urandom);
                cur[15:0]  = 16'($urandom);
            end
            if ($urandom_range(99) < 7) cur[30] = ~cur[30];
            sync_in  = ($urandom_range(99) < 12);
            user_rst = ($urandom_range(499) == 0);
            cfg_word = cur;
            step();
        end
        user_rst = 1'b0;
        sync_in  = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eq_coeff_loader.md
EQ_COEFF_LOADER -- requirements
Module: eq_coeff_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, coefficient address width ({input[2:0], chan[7:0]}); legal range 1..14.
REQ-002 SHALL have parameter COEFF_W, default 16, coefficient width; legal range 1..16.
REQ-003 SHALL have port user_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port user_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_word  in  32  software register word from the eq_coeff register: [31] write toggle, [30] commit toggle, [29:16] address (low ADDR_W bits used), [15:0] coefficient (low COEFF_W bits used).
REQ-006 SHALL have port sync_in  in  1  datapath frame sync pulse; bank swaps occur only on it.
REQ-007 SHALL have port ram_we  out  1  one-cycle coefficient RAM write strobe.
REQ-008 SHALL have port ram_waddr  out  ADDR_W+1  {shadow bank, address}.
REQ-009 SHALL have port ram_wdata  out  COEFF_W  coefficient to write.
REQ-010 SHALL have port active_bank  out  1  bank the equalizer datapath reads.
REQ-011 SHALL have port commit_done  out  1  one-cycle pulse on each bank swap.
REQ-012 SHALL have port busy  out  1  high while a commit is pending.

Function
REQ-013 SHALL register cfg_word once (cfg_q); events are decoded only from cfg_q.
REQ-014 SHALL raise a write event when cfg_q[31] differs from its previous registered value, and a commit event likewise for cfg_q[30]; level alone never triggers anything.
REQ-015 SHALL assert ram_we exactly 2 cycles after a write-toggle change on cfg_word, with ram_waddr = {~active_bank, cfg_q addr} and ram_wdata = cfg_q coeff.
REQ-016 SHALL implement states IDLE, WAIT_SYNC, SWAP: IDLE->WAIT_SYNC on commit event; WAIT_SYNC->SWAP on sync_in; SWAP->IDLE after one cycle.
REQ-017 SHALL, in SWAP, invert active_bank and pulse commit_done for that one cycle.
REQ-018 SHALL drive busy high in WAIT_SYNC and SWAP, low in IDLE.
REQ-019 SHALL, when write and commit events coincide, perform the write first, into the pre-swap shadow bank, then enter WAIT_SYNC.
REQ-020 SHALL, when sync_in coincides with the commit event, not swap on that sync; the swap waits for the next sync_in.
REQ-021 SHALL hold a write event arriving in WAIT_SYNC or SWAP in a one-deep pending slot, issuing it the cycle after SWAP, into the new shadow bank.
REQ-022 SHALL, when a second write arrives while the slot is full, overwrite the slot (last write wins).
REQ-023 SHALL ignore a commit event arriving in WAIT_SYNC or SWAP (no extra swap).

Reset
REQ-024 SHALL reset active_bank=0, ram_we=0, ram_waddr=0, ram_wdata=0, commit_done=0, busy=0, state=IDLE, pending slot empty.
REQ-025 SHALL, on the first cycle after reset deasserts, load both previous-toggle flops from cfg_q without raising events, so a register holding toggles at 1 causes no spurious write or commit.
REQ-026 SHALL abandon a pending commit or write on reset asserted mid-operation, with no swap and no write.

Configuration
REQ-027 SHALL, when macro EQ_COEFF_STATUS_EN is defined, add output status_word (32) = {swap_count[15:0], pending, busy, active_bank, 13'b0}, where swap_count is a 16-bit wrapping counter of swaps that resets to 0; without the macro, that port and counter SHALL not exist and behaviour is otherwise identical.

Structure
REQ-028 SHALL place cfg_word field-position constants, the state enumeration and the status layout in shared package eq_coeff_pkg.
REQ-029 SHALL use one sub-module, toggle_edge_det (prime-on-reset toggle change detector), instantiated for each of the two toggles.

Verification
REQ-030 SHALL check: after reset, cfg_word=0x8123_ABCD (addr 0x123, coeff 0xABCD) -> 2 cycles later ram_we=1, ram_waddr=0x923, ram_wdata=0xABCD, once.
REQ-031 SHALL check: commit toggle flip, sync_in 10 cycles later -> busy high during the wait, commit_done pulse 1 cycle after sync, active_bank=1, busy low the next cycle.
REQ-032 SHALL check: both toggles flip together with sync_in in the same cycle -> write to bank 1 addr, no swap, swap only on the following sync.
REQ-033 SHALL check: two writes (coeff 0x0001, then 0x0002) during WAIT_SYNC -> a single write of 0x0002 to the new shadow bank the cycle after SWAP.
REQ-034 SHALL check: reset released while cfg_word=0xC000_0000 -> no ram_we, no commit; then reset mid-WAIT_SYNC -> no swap, active_bank=0.
